// File: rtl/riscv_soc_pkg.sv
// Shared defines for the RV32I SoC: core widths, ROM depth, memory map and the ALU helper.
package riscv_soc_pkg;

   localparam int unsigned CPU_WIDTH           = 32;
   localparam int unsigned INST_MEM_ADDR_DEPTH = 1024;
   localparam int unsigned SIM_CLK_PERIOD      = 10;
   localparam int unsigned STRB_WIDTH          = 4;
   localparam logic [31:0] DM_BASE_DEF         = 32'h0000_0000;
   localparam logic [31:0] LED_ADDR_DEF        = 32'h1000_0000;

   typedef enum logic [6:0] {
      OpLui    = 7'b0110111,
      OpAuipc  = 7'b0010111,
      OpJal    = 7'b1101111,
      OpJalr   = 7'b1100111,
      OpBranch = 7'b1100011,
      OpLoad   = 7'b0000011,
      OpStore  = 7'b0100011,
      OpImm    = 7'b0010011,
      OpReg    = 7'b0110011
   } opcode_e;

   // alt selects sub for funct3=0 and arithmetic shift for funct3=5
   function automatic logic [31:0] alu(input logic [2:0] op, input logic alt,
                                       input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      case (op)
         3'd0:    r = alt ? a - b : a + b;
         3'd1:    r = a << b[4:0];
         3'd2:    r = {31'b0, $signed(a) < $signed(b)};
         3'd3:    r = {31'b0, a < b};
         3'd4:    r = a ^ b;
         3'd5:    r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'd6:    r = a | b;
         default: r = a & b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/data_mem.sv
// Data RAM: per-byte synchronous write, combinational read (old data when written in same cycle).
module data_mem #(
   parameter int unsigned DEPTH = 4096
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] idx,
   input  logic [3:0]               wstrb,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata
);

   logic [31:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/riscv.sv
// Single-cycle RV32I core: every instruction fetches, executes and writes back in one clock.
module riscv
   import riscv_soc_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [CPU_WIDTH-1:0]  dm_addr,
   output logic [CPU_WIDTH-1:0]  dm_wdata,
   output logic [STRB_WIDTH-1:0] dm_wstrb,
   output logic                  dm_we,
   output logic                  dm_re,
   input  logic [CPU_WIDTH-1:0]  dm_rdata
);

   localparam int unsigned IW = $clog2(INST_MEM_ADDR_DEPTH);

   logic [31:0] pc_q, pc_d, instr;
   logic [31:0] rs1_data, rs2_data, rd_wdata;
   logic        rd_we;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [2:0]  funct3;
   logic [1:0]  byte_off;
   logic [31:0] ld_shift, ld_data;
   logic [3:0]  st_strb;
   logic        br_take;
   opcode_e     opcode;

   riscv_inst_mem u_inst_mem_0 (.addr(pc_q[IW+1:2]), .inst(instr));

   riscv_regs u_regs_0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .rs1_addr (instr[19:15]),
      .rs2_addr (instr[24:20]),
      .rd_addr  (instr[11:7]),
      .rd_we    (rd_we),
      .rd_wdata (rd_wdata),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data)
   );

   assign opcode = opcode_e'(instr[6:0]);
   assign funct3 = instr[14:12];
   assign imm_i  = {{20{instr[31]}}, instr[31:20]};
   assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u  = {instr[31:12], 12'b0};
   assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // Sub-word stores are lane-aligned here; loads are realigned and extended after the read
   assign dm_addr  = rs1_data + ((opcode == OpStore) ? imm_s : imm_i);
   assign byte_off = dm_addr[1:0];
   assign dm_wdata = rs2_data << {byte_off, 3'b000};
   assign ld_shift = dm_rdata >> {byte_off, 3'b000};

   always_comb begin
      case (funct3[1:0])
         2'b00:   st_strb = 4'b0001 << byte_off;
         2'b01:   st_strb = 4'b0011 << byte_off;
         default: st_strb = 4'b1111;
      endcase
   end

   always_comb begin
      case (funct3)
         3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
         3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
         3'b100:  ld_data = {24'b0, ld_shift[7:0]};
         3'b101:  ld_data = {16'b0, ld_shift[15:0]};
         default: ld_data = ld_shift;
      endcase
   end

   always_comb begin
      case (funct3)
         3'b000:  br_take = rs1_data == rs2_data;
         3'b001:  br_take = rs1_data != rs2_data;
         3'b100:  br_take = $signed(rs1_data) < $signed(rs2_data);
         3'b101:  br_take = $signed(rs1_data) >= $signed(rs2_data);
         3'b110:  br_take = rs1_data < rs2_data;
         3'b111:  br_take = rs1_data >= rs2_data;
         default: br_take = 1'b0;
      endcase
   end

   always_comb begin
      pc_d     = pc_q + 32'd4;
      rd_we    = 1'b0;
      rd_wdata = '0;
      dm_we    = 1'b0;
      dm_re    = 1'b0;
      dm_wstrb = '0;
      case (opcode)
         OpLui:    begin rd_we = 1'b1; rd_wdata = imm_u; end
         OpAuipc:  begin rd_we = 1'b1; rd_wdata = pc_q + imm_u; end
         OpJal:    begin rd_we = 1'b1; rd_wdata = pc_q + 32'd4; pc_d = pc_q + imm_j; end
         OpJalr: begin
            rd_we    = 1'b1;
            rd_wdata = pc_q + 32'd4;
            pc_d     = (rs1_data + imm_i) & ~32'd1;
         end
         OpBranch: if (br_take) pc_d = pc_q + imm_b;
         OpLoad:   begin dm_re = 1'b1; rd_we = 1'b1; rd_wdata = ld_data; end
         OpStore:  begin dm_we = 1'b1; dm_wstrb = st_strb; end
         OpImm: begin
            rd_we    = 1'b1;
            rd_wdata = alu(funct3, (funct3 == 3'b101) && instr[30], rs1_data, imm_i);
         end
         OpReg:    begin rd_we = 1'b1; rd_wdata = alu(funct3, instr[30], rs1_data, rs2_data); end
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= '0;
      else        pc_q <= pc_d;
   end

endmodule

// File: rtl/riscv_inst_mem.sv
// Instruction ROM, word indexed, combinational read; contents are loaded by the bench or bitstream.
module riscv_inst_mem
   import riscv_soc_pkg::*;
(
   input  logic [$clog2(INST_MEM_ADDR_DEPTH)-1:0] addr,
   output logic [CPU_WIDTH-1:0]                   inst
);

   logic [CPU_WIDTH-1:0] inst_mem [0:INST_MEM_ADDR_DEPTH-1];

   assign inst = inst_mem[addr];

endmodule

// File: rtl/riscv_regs.sv
// 32 x 32-bit register file: two combinational read ports, one write port, x0 hardwired to zero.
module riscv_regs
   import riscv_soc_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [4:0]           rs1_addr,
   input  logic [4:0]           rs2_addr,
   input  logic [4:0]           rd_addr,
   input  logic                 rd_we,
   input  logic [CPU_WIDTH-1:0] rd_wdata,
   output logic [CPU_WIDTH-1:0] rs1_data,
   output logic [CPU_WIDTH-1:0] rs2_data
);

   logic [CPU_WIDTH-1:0] regs [0:31];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (rd_we && rd_addr != 5'd0) begin
         regs[rd_addr] <= rd_wdata;
      end
   end

   assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
   assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/soc_led_gpio.sv
// 2-bit LED register with read-back; LED_HEARTBEAT_EN turns led[0] into a free-running heartbeat.
module soc_led_gpio #(
   parameter int unsigned HB_DIV = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [1:0]  wdata,
   output logic [31:0] rdata,
   output logic [1:0]  led
);

   logic [1:0] led_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     led_q <= 2'b00;
      else if (wr_en) led_q <= wdata;
   end

   assign rdata = {30'b0, led_q};

`ifdef LED_HEARTBEAT_EN
   logic [HB_DIV-1:0] hb_cnt_q;
   logic              hb_q;

   // Toggle on counter wrap, i.e. once every 2**HB_DIV cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hb_cnt_q <= '0;
         hb_q     <= 1'b0;
      end else begin
         hb_cnt_q <= hb_cnt_q + HB_DIV'(1);
         if (&hb_cnt_q) hb_q <= ~hb_q;
      end
   end

   assign led = {led_q[1], hb_q};
`else
   assign led = led_q;
`endif

endmodule

// File: rtl/riscv_soc_top.sv
// SoC top: RV32I core, data RAM, LED register and inline address decoder.
// Build option: LED_HEARTBEAT_EN makes led[0] a heartbeat.
module riscv_soc_top
   import riscv_soc_pkg::*;
#(
   parameter int unsigned DM_ADDR_DEPTH = 4096,
   parameter logic [31:0] DM_BASE       = DM_BASE_DEF,
   parameter logic [31:0] LED_ADDR      = LED_ADDR_DEF,
   parameter int unsigned HB_DIV        = 24
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [1:0] led
);

   localparam int unsigned DW     = $clog2(DM_ADDR_DEPTH);
   localparam logic [32:0] DM_LEN = 33'(4 * DM_ADDR_DEPTH);

   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic [3:0]  dm_wstrb;
   logic        dm_we, dm_re;
   logic [32:0] ram_off;
   logic        ram_sel, led_sel;
   logic [31:0] ram_rdata, led_rdata;

   riscv u_riscv_0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_wstrb (dm_wstrb),
      .dm_we    (dm_we),
      .dm_re    (dm_re),
      .dm_rdata (dm_rdata)
   );

   // 33-bit offset: addresses below DM_BASE wrap to a huge value and miss the RAM window
   assign ram_off = {1'b0, dm_addr} - {1'b0, DM_BASE};
   assign ram_sel = ram_off < DM_LEN;
   assign led_sel = dm_addr[31:2] == LED_ADDR[31:2];

   data_mem #(.DEPTH(DM_ADDR_DEPTH)) u_data_mem_0 (
      .clk   (clk),
      .we    (ram_sel && dm_we),
      .idx   (DW'(ram_off >> 2)),
      .wstrb (dm_wstrb),
      .wdata (dm_wdata),
      .rdata (ram_rdata)
   );

   soc_led_gpio #(.HB_DIV(HB_DIV)) u_led_gpio_0 (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (led_sel && dm_we && dm_wstrb[0]),
      .wdata (dm_wdata[1:0]),
      .rdata (led_rdata),
      .led   (led)
   );

   always_comb begin
      dm_rdata = '0;
      if (dm_re) begin
         if (ram_sel)      dm_rdata = ram_rdata;
         else if (led_sel) dm_rdata = led_rdata;
      end
   end

endmodule

// File: tb/tb_riscv_soc_top.sv
// Bench for riscv_soc_top: loads small programs into the ROM and scores registers, LEDs and RAM.
module tb_riscv_soc_top;
   import riscv_soc_pkg::*;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] led;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned cyc;

   localparam int unsigned W_LED    = 32;
   localparam int unsigned W_RAM    = 33;
   localparam int unsigned RAM_WORD = 32'h40;

   typedef struct {
      string       tag;
      int unsigned what;
      logic [31:0] exp;
   } exp_t;

   exp_t        sb_q [$];
   logic [31:0] prog [$];

   riscv_soc_top dut (.clk(clk), .rst_n(rst_n), .led(led));

   always #(SIM_CLK_PERIOD / 2) clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd,
                                         input logic [6:0] op);
      return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
   endfunction

   function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
      return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_u(input int imm20, input int rd);
      return {imm20[19:0], rd[4:0], 7'b0110111};
   endfunction

   function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3,
                                         input int rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
   endfunction

   function automatic logic [31:0] observe(input int unsigned what);
      if (what < 32) return dut.u_riscv_0.u_regs_0.regs[what];
      if (what == W_LED) return {30'b0, led};
      return dut.u_data_mem_0.mem[RAM_WORD];
   endfunction

   task automatic expect_val(input string tag, input int unsigned what, input logic [31:0] exp);
      exp_t e;
      e.tag  = tag;
      e.what = what;
      e.exp  = exp;
      sb_q.push_back(e);
   endtask

   task automatic load_prog();
      for (int i = 0; i < INST_MEM_ADDR_DEPTH; i++) begin
         dut.u_riscv_0.u_inst_mem_0.inst_mem[i] = (i < prog.size()) ? prog[i] : 32'h0000_0013;
      end
   endtask

   // Wait for the end-of-test marker, then drain the scoreboard against the final state
   task automatic run_to_end(input int unsigned budget);
      int unsigned n = 0;
      while (observe(26) !== 32'd1 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("end_marker_x26", observe(26), 32'd1);
      @(posedge clk);
      #1;
      check_eq("pass_flag_x27", observe(27), 32'd1);
      while (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check_eq(e.tag, observe(e.what), e.exp);
      end
   endtask

   task automatic build_prog1();
      prog = {};
      prog.push_back(enc_u(32'h10000, 5));              // x5 = LED_ADDR
      prog.push_back(enc_i(3, 0, 0, 6, 7'h13));         // x6 = 3
      prog.push_back(enc_s(0, 6, 5, 2));                // sw x6 -> LED
      prog.push_back(enc_i(0, 5, 2, 7, 7'h03));         // lw x7 <- LED
      prog.push_back(enc_i(128, 0, 0, 8, 7'h13));       // x8 = 0x80
      prog.push_back(enc_i(256, 0, 0, 9, 7'h13));       // x9 = 0x100
      prog.push_back(enc_u(32'h12345, 10));
      prog.push_back(enc_i(32'h678, 10, 0, 10, 7'h13)); // x10 = 0x12345678
      prog.push_back(enc_s(0, 10, 9, 2));               // sw x10 -> RAM 0x100
      prog.push_back(enc_s(1, 8, 9, 0));                // sb x8 -> byte 1
      prog.push_back(enc_i(1, 9, 0, 11, 7'h03));        // lb
      prog.push_back(enc_i(1, 9, 4, 12, 7'h03));        // lbu
      prog.push_back(enc_i(0, 9, 2, 13, 7'h03));        // lw
      prog.push_back(enc_u(32'h20000, 14));             // x14 = unmapped
      prog.push_back(enc_i(-1, 0, 0, 15, 7'h13));
      prog.push_back(enc_i(0, 14, 2, 15, 7'h03));       // lw unmapped
      prog.push_back(enc_s(0, 10, 14, 2));              // sw unmapped
      prog.push_back(enc_i(0, 9, 2, 16, 7'h03));
      prog.push_back(enc_i(0, 9, 1, 17, 7'h03));        // lh
      prog.push_back(enc_r(32, 6, 10, 0, 18));          // sub
      prog.push_back(enc_i(-1, 0, 0, 19, 7'h13));
      prog.push_back(enc_i(4, 5, 2, 19, 7'h03));        // lw LED_ADDR+4 (unmapped)
      prog.push_back(enc_u(32'h4, 20));                 // x20 = end of RAM
      prog.push_back(enc_s(-4, 10, 20, 2));             // last RAM word
      prog.push_back(enc_i(-4, 20, 2, 21, 7'h03));
      prog.push_back(enc_i(-1, 0, 0, 22, 7'h13));
      prog.push_back(enc_i(0, 20, 2, 22, 7'h03));       // first address past RAM
      prog.push_back(enc_i(1, 0, 0, 27, 7'h13));
      prog.push_back(enc_i(1, 0, 0, 26, 7'h13));
      prog.push_back(32'h0000_006f);                    // spin
   endtask

   task automatic build_prog2();
      prog = {};
      prog.push_back(enc_i(256, 0, 2, 7, 7'h03));       // x7 <- RAM 0x100
      prog.push_back(enc_i(1, 7, 0, 7, 7'h13));
      prog.push_back(enc_s(256, 7, 0, 2));              // RAM 0x100 <- x7+1
      prog.push_back(enc_u(32'h10000, 5));
      prog.push_back(enc_i(1, 0, 0, 6, 7'h13));
      prog.push_back(enc_s(0, 6, 5, 2));                // led = 01
      prog.push_back(enc_i(1, 0, 0, 27, 7'h13));
      prog.push_back(enc_i(1, 0, 0, 26, 7'h13));
      prog.push_back(32'h0000_006f);
   endtask

   initial begin
      int unsigned n;

      build_prog1();
      load_prog();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_eq("reset_led", {30'b0, led}, 32'd0);
      for (int i = 0; i < 32; i++) check_eq($sformatf("reset_x%0d", i), observe(i), 32'd0);

      expect_val("lui_led_base_x5", 5, 32'h1000_0000);
      expect_val("led_readback_x7", 7, 32'h0000_0003);
      expect_val("lb_sign_x11", 11, 32'hFFFF_FF80);
      expect_val("lbu_zero_x12", 12, 32'h0000_0080);
      expect_val("sb_other_bytes_x13", 13, 32'h1234_8078);
      expect_val("unmapped_rd_x15", 15, 32'h0);
      expect_val("ram_after_unmapped_sw_x16", 16, 32'h1234_8078);
      expect_val("lh_sign_x17", 17, 32'hFFFF_8078);
      expect_val("sub_x18", 18, 32'h1234_5675);
      expect_val("led_plus4_unmapped_x19", 19, 32'h0);
      expect_val("ram_last_word_x21", 21, 32'h1234_5678);
      expect_val("ram_end_unmapped_x22", 22, 32'h0);
      expect_val("led_after_unmapped_sw", W_LED, 32'd3);
      expect_val("ram_word_0x100", W_RAM, 32'h1234_8078);

      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (observe(5) == 32'd0 && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("first_fetch_x5", observe(5), 32'h1000_0000);
      n = 0;
      while (led !== 2'b11 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("led_after_sw", {30'b0, led}, 32'd3);
      run_to_end(500);

      // RAM survives reset, so each run of program 2 bumps the same word
      rst_n = 1'b0;
      build_prog2();
      load_prog();
      expect_val("run1_x7", 7, 32'h1234_8079);
      expect_val("run1_ram", W_RAM, 32'h1234_8079);
      expect_val("run1_led", W_LED, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      run_to_end(500);

      while (cyc < 100) begin
         @(posedge clk);
         #1;
      end
      check_eq("led_before_midrun_rst", {30'b0, led}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("led_async_clear", {30'b0, led}, 32'd0);
      check_eq("midrun_rst_x7", observe(7), 32'd0);
      check_eq("midrun_rst_x26", observe(26), 32'd0);
      check_eq("midrun_rst_x27", observe(27), 32'd0);
      expect_val("rerun_x7", 7, 32'h1234_807A);
      expect_val("rerun_ram", W_RAM, 32'h1234_807A);
      expect_val("rerun_led", W_LED, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      run_to_end(500);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
